// File: rtl/prbs_pkg.sv
// Shared types and polynomial constants for the PRBS pattern generator.
package prbs_pkg;

   localparam int unsigned LFSR_W = 31;

   typedef enum logic [1:0] {
      MODE_PRBS7  = 2'd0,
      MODE_PRBS15 = 2'd1,
      MODE_PRBS23 = 2'd2,
      MODE_PRBS31 = 2'd3
   } prbs_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_PRBS     = 2'd2
   } prbs_state_e;

   localparam int unsigned DEG_PRBS7  = 7;
   localparam int unsigned TAP_PRBS7  = 6;
   localparam int unsigned DEG_PRBS15 = 15;
   localparam int unsigned TAP_PRBS15 = 14;
   localparam int unsigned DEG_PRBS23 = 23;
   localparam int unsigned TAP_PRBS23 = 18;
   localparam int unsigned DEG_PRBS31 = 31;
   localparam int unsigned TAP_PRBS31 = 28;

   function automatic int unsigned prbs_degree(prbs_mode_e m);
      case (m)
         MODE_PRBS7:  return DEG_PRBS7;
         MODE_PRBS15: return DEG_PRBS15;
         MODE_PRBS23: return DEG_PRBS23;
         default:     return DEG_PRBS31;
      endcase
   endfunction

   function automatic int unsigned prbs_tap(prbs_mode_e m);
      case (m)
         MODE_PRBS7:  return TAP_PRBS7;
         MODE_PRBS15: return TAP_PRBS15;
         MODE_PRBS23: return TAP_PRBS23;
         default:     return TAP_PRBS31;
      endcase
   endfunction

   // Low-degree-bits mask of the active polynomial.
   function automatic logic [LFSR_W-1:0] prbs_mask(prbs_mode_e m);
      return LFSR_W'((64'd1 << prbs_degree(m)) - 64'd1);
   endfunction

endpackage

// File: rtl/prbs_pattern_gen_if.sv
// Valid/ready beat stream carrying generator output to its sink.
interface prbs_pattern_gen_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/prbs_lfsr_step.sv
// Combinational STEPS-deep Fibonacci LFSR advance; bits_o holds oldest bit in MSB.
module prbs_lfsr_step
   import prbs_pkg::*;
#(
   parameter int unsigned STEPS = 8
) (
   input  logic [LFSR_W-1:0] state_i,
   input  prbs_mode_e        mode_i,
   output logic [LFSR_W-1:0] state_o,
   output logic [STEPS-1:0]  bits_o
);

   always_comb begin
      logic [LFSR_W-1:0] s;
      logic [LFSR_W-1:0] msk;
      logic [4:0]        hi;
      logic [4:0]        lo;
      logic              fb;
      hi     = 5'(prbs_degree(mode_i) - 1);
      lo     = 5'(prbs_tap(mode_i) - 1);
      msk    = prbs_mask(mode_i);
      s      = state_i;
      fb     = 1'b0;
      bits_o = '0;
      for (int i = 0; i < int'(STEPS); i++) begin
         fb = s[hi] ^ s[lo];
         s  = ((s << 1) | LFSR_W'(fb)) & msk;
         bits_o[STEPS-1-i] = fb;
      end
      state_o = s;
   end

endmodule

// File: rtl/prbs_pattern_gen.sv
// Seed preamble followed by a selectable PRBS stream on a valid/ready port.
// Optional one-shot bit-error injection when PRBS_ERR_INJ_EN is defined.
module prbs_pattern_gen
   import prbs_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SEED_W = 32
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              start,
   input  logic              abort,
`ifdef PRBS_ERR_INJ_EN
   input  logic              err_inj,
`endif
   input  logic [1:0]        mode,
   input  logic [7:0]        n_rep,
   input  logic [SEED_W-1:0] seed,
   prbs_pattern_gen_if.master out_if,
   output logic              busy,
   output logic              phase
);

   localparam int unsigned CHUNKS = SEED_W / DATA_W;
   localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   localparam logic [1:0] IDLE     = ST_IDLE;
   localparam logic [1:0] PREAMBLE = ST_PREAMBLE;
   localparam logic [1:0] PRBS     = ST_PRBS;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] out_data_q, out_data_d, beat_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d, phase_q, phase_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   prbs_mode_e        mode_q, mode_d;
   logic [SEED_W-1:0] seed_q, seed_d;
   logic [7:0]        n_rep_q, n_rep_d, rep_q, rep_d;
   logic [CNT_W-1:0]  chunk_q, chunk_d;

   logic [LFSR_W-1:0] load_raw, load_val, step_in, step_next;
   prbs_mode_e        step_mode;
   logic [DATA_W-1:0] step_bits;
   logic              hs;

   function automatic logic [DATA_W-1:0] chunk_of(logic [SEED_W-1:0] w, logic [CNT_W-1:0] idx);
      return DATA_W'(w >> (DATA_W * idx));
   endfunction

   // A zero seed would lock the LFSR, so it is replaced by 1.
   assign load_raw  = seed[LFSR_W-1:0] & prbs_mask(prbs_mode_e'(mode));
   assign load_val  = (load_raw == '0) ? LFSR_W'(1) : load_raw;
   assign step_in   = start ? load_val : lfsr_q;
   assign step_mode = start ? prbs_mode_e'(mode) : mode_q;
   assign hs        = out_valid_q && out_if.out_ready && !start && !abort;

   prbs_lfsr_step #(.STEPS(DATA_W)) u_step (
      .state_i (step_in),
      .mode_i  (step_mode),
      .state_o (step_next),
      .bits_o  (step_bits)
   );

   always_comb begin
      state_d     = state_q;
      beat_d      = out_data_q;
      out_valid_d = out_valid_q;
      lfsr_d      = lfsr_q;
      mode_d      = mode_q;
      seed_d      = seed_q;
      n_rep_d     = n_rep_q;
      rep_d       = rep_q;
      chunk_d     = chunk_q;
      if (start) begin
         mode_d      = prbs_mode_e'(mode);
         seed_d      = seed;
         n_rep_d     = n_rep;
         rep_d       = '0;
         chunk_d     = '0;
         out_valid_d = 1'b1;
         if (n_rep == 8'd0) begin
            state_d = PRBS;
            lfsr_d  = step_next;
            beat_d  = step_bits;
         end else begin
            state_d = PREAMBLE;
            lfsr_d  = load_val;
            beat_d  = seed[DATA_W-1:0];
         end
      end else if (abort) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         beat_d      = '0;
         rep_d       = '0;
         chunk_d     = '0;
      end else if (hs) begin
         case (state_q)
            PREAMBLE: begin
               if (chunk_q == CNT_W'(CHUNKS - 1)) begin
                  chunk_d = '0;
                  if (rep_q == 8'(n_rep_q - 8'd1)) begin
                     state_d = PRBS;
                     lfsr_d  = step_next;
                     beat_d  = step_bits;
                  end else begin
                     rep_d  = rep_q + 8'd1;
                     beat_d = chunk_of(seed_q, '0);
                  end
               end else begin
                  chunk_d = CNT_W'(chunk_q + 1'b1);
                  beat_d  = chunk_of(seed_q, CNT_W'(chunk_q + 1'b1));
               end
            end
            PRBS: begin
               lfsr_d = step_next;
               beat_d = step_bits;
            end
            default: ;
         endcase
      end
      busy_d  = (state_d != IDLE);
      phase_d = (state_d == PRBS);
   end

`ifdef PRBS_ERR_INJ_EN
   logic arm_q, arm_d, flip_q, flip_d, prbs_load;

   // Armed flag persists until the flipped beat is actually accepted.
   assign prbs_load = (state_d == PRBS) && (start || hs);

   always_comb begin
      arm_d      = arm_q | err_inj;
      flip_d     = flip_q;
      out_data_d = beat_d;
      if (hs && flip_q) begin
         arm_d  = err_inj;
         flip_d = 1'b0;
      end
      if (start || abort) flip_d = 1'b0;
      if (prbs_load && arm_d) begin
         out_data_d[0] = ~beat_d[0];
         flip_d        = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         arm_q  <= 1'b0;
         flip_q <= 1'b0;
      end else begin
         arm_q  <= arm_d;
         flip_q <= flip_d;
      end
   end
`else
   assign out_data_d = beat_d;
`endif

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= IDLE;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         phase_q     <= 1'b0;
         lfsr_q      <= LFSR_W'(1);
         mode_q      <= MODE_PRBS7;
         seed_q      <= '0;
         n_rep_q     <= '0;
         rep_q       <= '0;
         chunk_q     <= '0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         phase_q     <= phase_d;
         lfsr_q      <= lfsr_d;
         mode_q      <= mode_d;
         seed_q      <= seed_d;
         n_rep_q     <= n_rep_d;
         rep_q       <= rep_d;
         chunk_q     <= chunk_d;
      end
   end

   assign out_if.out_data  = out_data_q;
   assign out_if.out_valid = out_valid_q;
   assign busy             = busy_q;
   assign phase            = phase_q;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Directed self-checking bench for prbs_pattern_gen (DATA_W=8, SEED_W=32).
module tb_prbs_pattern_gen;

   logic        CLK;
   logic        RSTn;
   logic        start;
   logic        abort;
   logic [1:0]  mode;
   logic [7:0]  n_rep;
   logic [31:0] seed;
   logic        busy;
   logic        phase;
`ifdef PRBS_ERR_INJ_EN
   logic        err_inj;
`endif

   int checks   = 0;
   int failures = 0;

   logic [6:0] model_st;

   prbs_pattern_gen_if #(.DATA_W(8)) out_if ();

   prbs_pattern_gen #(.DATA_W(8), .SEED_W(32)) dut (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .start  (start),
      .abort  (abort),
`ifdef PRBS_ERR_INJ_EN
      .err_inj(err_inj),
`endif
      .mode   (mode),
      .n_rep  (n_rep),
      .seed   (seed),
      .out_if (out_if),
      .busy   (busy),
      .phase  (phase)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // PRBS7 reference: x^7+x^6+1, 8 bits per beat, first generated bit in MSB.
   task automatic model_seed(input logic [31:0] s);
      model_st = s[6:0];
      if (model_st == 7'd0) model_st = 7'd1;
   endtask

   task automatic model_beat(output logic [7:0] b);
      logic fb;
      b = 8'h00;
      for (int k = 0; k < 8; k++) begin
         fb       = model_st[6] ^ model_st[5];
         model_st = {model_st[5:0], fb};
         b        = {b[6:0], fb};
      end
   endtask

   task automatic do_start(input logic [31:0] s, input logic [7:0] nr, input logic [1:0] m);
      seed  = s;
      n_rep = nr;
      mode  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic go_idle();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      tick();
      tick();
      RSTn = 1'b1;
      tick();
      checks++;
      if (out_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_if.out_valid); end
      checks++;
      if (out_if.out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", out_if.out_data); end
      checks++;
      if (busy !== 1'b0 || phase !== 1'b0) begin failures++; $display("FAIL reset_busy_phase: got %b%b expected 00", busy, phase); end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (out_if.out_valid !== 1'b0) begin failures++; $display("FAIL idle_no_beat: got %b expected 0", out_if.out_valid); end
      end
   endtask

   task automatic test_preamble();
      logic [7:0] exp_pre [8];
      logic [7:0] e;
      exp_pre = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      out_if.out_ready = 1'b1;
      do_start(32'hDDCCBBAA, 8'd2, 2'd0);
      seed  = 32'h12345678;
      n_rep = 8'd0;
      mode  = 2'd3;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_if.out_data !== exp_pre[i] || out_if.out_valid !== 1'b1 || phase !== 1'b0 || busy !== 1'b1)
            begin failures++; $display("FAIL preamble_beat%0d: got %h v%b p%b b%b expected %h v1 p0 b1", i, out_if.out_data, out_if.out_valid, phase, busy, exp_pre[i]); end
         tick();
      end
      model_seed(32'hDDCCBBAA);
      for (int i = 0; i < 3; i++) begin
         model_beat(e);
         checks++;
         if (out_if.out_data !== e || phase !== 1'b1 || out_if.out_valid !== 1'b1)
            begin failures++; $display("FAIL preamble_prbs%0d: got %h p%b expected %h p1", i, out_if.out_data, phase, e); end
         tick();
      end
      go_idle();
   endtask

   task automatic test_prbs7();
      logic [7:0] e;
      logic       rdy;
      out_if.out_ready = 1'b1;
      do_start(32'h00000001, 8'd0, 2'd0);
      checks++;
      if (out_if.out_data !== 8'h06 || phase !== 1'b1)
         begin failures++; $display("FAIL prbs7_first: got %h p%b expected 06 p1", out_if.out_data, phase); end
      model_seed(32'h00000001);
      for (int n = 0; n < 200; n++) begin
         model_beat(e);
         if (n == 1) begin
            checks++;
            if (e !== 8'h14) begin failures++; $display("FAIL prbs7_model_second: got %h expected 14", e); end
         end
         do begin
            rdy = ($urandom_range(0, 3) != 0);
            out_if.out_ready = rdy;
            checks++;
            if (out_if.out_data !== e || out_if.out_valid !== 1'b1)
               begin failures++; $display("FAIL prbs7_beat%0d: got %h v%b expected %h v1", n, out_if.out_data, out_if.out_valid, e); end
            tick();
         end while (!rdy);
      end
      out_if.out_ready = 1'b1;
      go_idle();
   endtask

   task automatic test_zero_seed();
      out_if.out_ready = 1'b1;
      do_start(32'h00000000, 8'd0, 2'd0);
      checks++;
      if (out_if.out_data !== 8'h06) begin failures++; $display("FAIL zero_seed_first: got %h expected 06", out_if.out_data); end
      tick();
      checks++;
      if (out_if.out_data !== 8'h14) begin failures++; $display("FAIL zero_seed_second: got %h expected 14", out_if.out_data); end
      go_idle();
   endtask

   task automatic test_backpressure();
      logic [7:0] e;
      out_if.out_ready = 1'b1;
      do_start(32'hDDCCBBAA, 8'd1, 2'd0);
      checks++;
      if (out_if.out_data !== 8'hAA) begin failures++; $display("FAIL bp_first: got %h expected AA", out_if.out_data); end
      tick();
      out_if.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (out_if.out_data !== 8'hBB || out_if.out_valid !== 1'b1)
            begin failures++; $display("FAIL bp_hold%0d: got %h v%b expected BB v1", k, out_if.out_data, out_if.out_valid); end
         tick();
      end
      out_if.out_ready = 1'b1;
      checks++;
      if (out_if.out_data !== 8'hBB) begin failures++; $display("FAIL bp_release: got %h expected BB", out_if.out_data); end
      tick();
      checks++;
      if (out_if.out_data !== 8'hCC) begin failures++; $display("FAIL bp_next_cc: got %h expected CC", out_if.out_data); end
      tick();
      checks++;
      if (out_if.out_data !== 8'hDD) begin failures++; $display("FAIL bp_next_dd: got %h expected DD", out_if.out_data); end
      tick();
      model_seed(32'hDDCCBBAA);
      model_beat(e);
      checks++;
      if (out_if.out_data !== e || phase !== 1'b1)
         begin failures++; $display("FAIL bp_prbs_entry: got %h p%b expected %h p1", out_if.out_data, phase, e); end
      go_idle();
   endtask

   task automatic test_restart_abort();
      out_if.out_ready = 1'b1;
      do_start(32'h00000001, 8'd0, 2'd0);
      tick();
      tick();
      do_start(32'hDDCCBBAA, 8'd1, 2'd0);
      checks++;
      if (out_if.out_data !== 8'hAA || phase !== 1'b0 || out_if.out_valid !== 1'b1)
         begin failures++; $display("FAIL restart_first: got %h p%b v%b expected AA p0 v1", out_if.out_data, phase, out_if.out_valid); end
      tick();
      checks++;
      if (out_if.out_data !== 8'hBB) begin failures++; $display("FAIL restart_second: got %h expected BB", out_if.out_data); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (out_if.out_valid !== 1'b0 || busy !== 1'b0 || phase !== 1'b0)
         begin failures++; $display("FAIL abort_idle: got v%b b%b p%b expected v0 b0 p0", out_if.out_valid, busy, phase); end
      tick();
      checks++;
      if (out_if.out_valid !== 1'b0) begin failures++; $display("FAIL abort_stays_idle: got %b expected 0", out_if.out_valid); end
      do_start(32'h00000001, 8'd0, 2'd0);
      tick();
      RSTn = 1'b0;
      #1;
      checks++;
      if (out_if.out_valid !== 1'b0 || out_if.out_data !== 8'h00 || busy !== 1'b0 || phase !== 1'b0)
         begin failures++; $display("FAIL midrun_reset: got v%b d%h b%b p%b expected all 0", out_if.out_valid, out_if.out_data, busy, phase); end
      tick();
      RSTn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_if.out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_no_beat: got %b expected 0", out_if.out_valid); end
      end
   endtask

   task automatic test_start_abort_same();
      out_if.out_ready = 1'b1;
      abort = 1'b1;
      do_start(32'hDDCCBBAA, 8'd1, 2'd0);
      abort = 1'b0;
      checks++;
      if (out_if.out_valid !== 1'b1 || out_if.out_data !== 8'hAA || busy !== 1'b1)
         begin failures++; $display("FAIL start_wins: got v%b d%h b%b expected v1 dAA b1", out_if.out_valid, out_if.out_data, busy); end
      tick();
      checks++;
      if (out_if.out_data !== 8'hBB) begin failures++; $display("FAIL start_wins_next: got %h expected BB", out_if.out_data); end
      go_idle();
   endtask

`ifdef PRBS_ERR_INJ_EN
   task automatic test_err_inj();
      logic [7:0] e;
      out_if.out_ready = 1'b1;
      err_inj = 1'b1;
      tick();
      err_inj = 1'b0;
      do_start(32'h00000001, 8'd0, 2'd0);
      checks++;
      if (out_if.out_data !== 8'h07) begin failures++; $display("FAIL err_inj_flip: got %h expected 07", out_if.out_data); end
      model_seed(32'h00000001);
      model_beat(e);
      for (int i = 0; i < 5; i++) begin
         tick();
         model_beat(e);
         checks++;
         if (out_if.out_data !== e) begin failures++; $display("FAIL err_inj_after%0d: got %h expected %h", i, out_if.out_data, e); end
      end
      go_idle();
   endtask
`endif

   initial begin
      RSTn             = 1'b0;
      start            = 1'b0;
      abort            = 1'b0;
      mode             = 2'd0;
      n_rep            = 8'd0;
      seed             = 32'h0;
      out_if.out_ready = 1'b0;
`ifdef PRBS_ERR_INJ_EN
      err_inj          = 1'b0;
`endif
      test_reset();
      test_preamble();
      test_prbs7();
      test_zero_seed();
      test_backpressure();
      test_restart_abort();
      test_start_abort_same();
`ifdef PRBS_ERR_INJ_EN
      test_err_inj();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
